// File: rtl/bit_mem_ctrl.sv
// Arbiter/sequencer for a falling-edge single-bit RAM: READ, WRITE and SET/CLR/CPL read-modify-write.
// Define BIT_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module bit_mem_ctrl #(
    parameter int unsigned ADDRWIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [2:0]           req0_op,
    input  logic [ADDRWIDTH-1:0] req0_addr,
    input  logic                 req0_wbit,
    output logic                 req0_ack,
    input  logic                 req1_valid,
    input  logic [2:0]           req1_op,
    input  logic [ADDRWIDTH-1:0] req1_addr,
    input  logic                 req1_wbit,
    output logic                 req1_ack,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic                 rsp_bit,
    output logic                 busy,
    output logic                 mem_cs,
    output logic                 mem_rw,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic                 mem_din,
    input  logic                 mem_dout
);

    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_CPL   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RMW_WR
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_op;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic                   r_wbit;
    logic                   r_id;
    logic                   r_old;
    logic                   r_ack0;
    logic                   r_ack1;
    logic                   r_rsp_valid;
    logic                   r_rsp_id;
    logic                   r_rsp_bit;

    logic                   w_any;
    logic                   w_gnt;
    logic                   w_is_rmw;
    logic [2:0]             w_sel_op;
    logic [ADDRWIDTH-1:0]   w_sel_addr;
    logic                   w_sel_wbit;

    assign w_any    = req0_valid | req1_valid;
    assign w_is_rmw = (r_op == OP_SET) | (r_op == OP_CLR) | (r_op == OP_CPL);

`ifdef BIT_ARB_RR_EN
    // r_ptr holds the winner of the last contention; lone requests leave it alone
    logic w_contend;
    logic r_ptr;

    assign w_contend = req0_valid & req1_valid;
    assign w_gnt     = w_contend ? ~r_ptr : ~req0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b1;
        end else if (r_state == ST_IDLE && w_contend) begin
            r_ptr <= w_gnt;
        end
    end
`else
    assign w_gnt = ~req0_valid;
`endif

    assign w_sel_op   = w_gnt ? req1_op   : req0_op;
    assign w_sel_addr = w_gnt ? req1_addr : req0_addr;
    assign w_sel_wbit = w_gnt ? req1_wbit : req0_wbit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next = ST_ACCESS;
            ST_ACCESS: w_next = w_is_rmw ? ST_RMW_WR : ST_IDLE;
            ST_RMW_WR: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_addr      <= '0;
            r_wbit      <= 1'b0;
            r_id        <= 1'b0;
            r_old       <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_bit   <= 1'b0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op   <= w_sel_op;
                        r_addr <= w_sel_addr;
                        r_wbit <= w_sel_wbit;
                        r_id   <= w_gnt;
                        r_ack0 <= ~w_gnt;
                        r_ack1 <= w_gnt;
                    end
                end
                ST_ACCESS: begin
                    if (w_is_rmw) begin
                        r_old <= mem_dout;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_bit   <= (r_op == OP_WRITE) ? r_wbit : mem_dout;
                    end
                end
                ST_RMW_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_bit   <= r_old;
                end
                default: ;
            endcase
        end
    end

    // RAM strobes decode from state only, so reset deselects the RAM before the next falling edge
    always_comb begin
        mem_cs  = 1'b1;
        mem_rw  = 1'b1;
        mem_din = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                mem_cs = 1'b0;
                if (r_op == OP_WRITE) begin
                    mem_rw  = 1'b0;
                    mem_din = r_wbit;
                end
            end
            ST_RMW_WR: begin
                mem_cs = 1'b0;
                mem_rw = 1'b0;
                case (r_op)
                    OP_SET:  mem_din = 1'b1;
                    OP_CLR:  mem_din = 1'b0;
                    default: mem_din = ~r_old;
                endcase
            end
            default: ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign busy      = (r_state != ST_IDLE);
    assign req0_ack  = r_ack0;
    assign req1_ack  = r_ack1;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_bit   = r_rsp_bit;

endmodule

// File: tb/tb_bit_mem_ctrl.sv
// Bench for bit_mem_ctrl: falling-edge bit RAM model plus an abstract per-command reference model.
module tb_bit_mem_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic [2:0]    req0_op = '0;
    logic [AW-1:0] req0_addr = '0;
    logic          req0_wbit = 1'b0;
    logic          req0_ack;
    logic          req1_valid = 1'b0;
    logic [2:0]    req1_op = '0;
    logic [AW-1:0] req1_addr = '0;
    logic          req1_wbit = 1'b0;
    logic          req1_ack;
    logic          rsp_valid;
    logic          rsp_id;
    logic          rsp_bit;
    logic          busy;
    logic          mem_cs;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic          mem_din;
    logic          mem_dout = 1'b0;

    logic ram [0:NW-1];
    logic ref_mem [0:NW-1];
    int   n_wr = 0;
    int   n_vec = 0;
    int   n_err = 0;
`ifdef BIT_ARB_RR_EN
    int   last_win = 1;
`endif

    bit_mem_ctrl #(.ADDRWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr),
        .req0_wbit(req0_wbit), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr),
        .req1_wbit(req1_wbit), .req1_ack(req1_ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bit(rsp_bit), .busy(busy),
        .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!mem_cs) begin
            if (mem_rw) begin
                mem_dout <= ram[mem_addr];
            end else begin
                ram[mem_addr] <= mem_din;
                n_wr <= n_wr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // result bit and new stored bit for one command, straight from the opcode table
    task automatic model(input logic [2:0] op, input logic old, input logic w,
                         output logic res, output logic nv);
        res = (op == 3'd1) ? w : old;
        case (op)
            3'd1:    nv = w;
            3'd2:    nv = 1'b1;
            3'd3:    nv = 1'b0;
            3'd4:    nv = ~old;
            default: nv = old;
        endcase
    endtask

    task automatic present(input int p, input logic [2:0] op, input logic [AW-1:0] a, input logic w);
        if (p == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_addr = a; req0_wbit = w;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_addr = a; req1_wbit = w;
        end
    endtask

    task automatic serve(input int p, input logic [2:0] op, input logic [AW-1:0] a, input logic w);
        logic exp_bit;
        logic exp_new;
        bit   rmw;
        int   wr0;
        rmw = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        model(op, ref_mem[a], w, exp_bit, exp_new);
        wr0 = n_wr;
        step();
        chk("ack_win", (p == 0) ? req0_ack : req1_ack, 1'b1);
        chk("ack_lose", (p == 0) ? req1_ack : req0_ack, 1'b0);
        chk("busy_acc", busy, 1'b1);
        chk("cs_acc", mem_cs, 1'b0);
        chk("addr_acc", mem_addr, a);
        chk("rw_acc", mem_rw, (op == 3'd1) ? 1'b0 : 1'b1);
        if (op == 3'd1) chk("din_wr", mem_din, w);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (rmw) begin
            step();
            chk("rsp_early", rsp_valid, 1'b0);
            chk("cs_rmw", mem_cs, 1'b0);
            chk("rw_rmw", mem_rw, 1'b0);
            chk("addr_rmw", mem_addr, a);
            chk("din_rmw", mem_din, exp_new);
        end
        step();
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_id", rsp_id, p[0]);
        chk("rsp_bit", rsp_bit, exp_bit);
        chk("busy_done", busy, 1'b0);
        chk("cs_idle", mem_cs, 1'b1);
        chk("writes", n_wr - wr0, (op == 3'd1 || rmw) ? 1 : 0);
        ref_mem[a] = exp_new;
    endtask

    task automatic issue(input int p, input logic [2:0] op, input logic [AW-1:0] a, input logic w);
        present(p, op, a, w);
        serve(p, op, a, w);
    endtask

    task automatic contend(input logic [2:0] op0, input logic [AW-1:0] a0, input logic w0,
                           input logic [2:0] op1, input logic [AW-1:0] a1, input logic w1);
        int win;
`ifdef BIT_ARB_RR_EN
        win = 1 - last_win;
        last_win = win;
`else
        win = 0;
`endif
        present(0, op0, a0, w0);
        present(1, op1, a1, w1);
        if (win == 0) begin
            serve(0, op0, a0, w0);
            serve(1, op1, a1, w1);
        end else begin
            serve(1, op1, a1, w1);
            serve(0, op0, a0, w0);
        end
    endtask

    initial begin
        int wr0;
        repeat (2) step();
        chk("rst_ack0", req0_ack, 1'b0);
        chk("rst_ack1", req1_ack, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_bit", rsp_bit, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cs", mem_cs, 1'b1);
        chk("rst_rw", mem_rw, 1'b1);
        chk("rst_din", mem_din, 1'b0);
        chk("rst_addr", mem_addr, '0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);

        for (int i = 0; i < int'(NW); i++) issue(i % 2, 3'd1, AW'(i), 1'($urandom));

        issue(0, 3'd1, 3'd5, 1'b1);
        issue(0, 3'd0, 3'd5, 1'b0);

        issue(1, 3'd1, 3'd3, 1'b0);
        issue(1, 3'd4, 3'd3, 1'b0);
        issue(1, 3'd0, 3'd3, 1'b0);
        issue(1, 3'd4, 3'd3, 1'b0);
        chk("cpl_final", ram[3], 1'b0);

        issue(0, 3'd1, 3'd2, 1'b1);
        contend(3'd2, 3'd2, 1'b0, 3'd3, 3'd2, 1'b0);
        contend(3'd2, 3'd2, 1'b0, 3'd3, 3'd2, 1'b0);

        issue(0, 3'd1, 3'd6, 1'b1);
        issue(0, 3'd7, 3'd6, 1'b0);
        chk("illegal_keep", ram[6], 1'b1);

        issue(0, 3'd1, 3'd4, 1'b0);
        wr0 = n_wr;
        present(0, 3'd2, 3'd4, 1'b0);
        step();
        chk("abort_ack", req0_ack, 1'b1);
        req0_valid = 1'b0;
        step();
        chk("abort_cs_pre", mem_cs, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", mem_cs, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rsp", rsp_valid, 1'b0);
        step();
        step();
        chk("abort_writes", n_wr - wr0, 0);
        chk("abort_rsp2", rsp_valid, 1'b0);
        rst_n = 1'b1;
`ifdef BIT_ARB_RR_EN
        last_win = 1;
`endif
        issue(0, 3'd0, 3'd4, 1'b0);

        present(0, 3'd0, 3'd5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("b2b_ack", req0_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("b2b_busy", busy, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("b2b_rsp", rsp_valid, (i % 2 == 1) ? 1'b1 : 1'b0);
            if (i % 2 == 1) chk("b2b_bit", rsp_bit, ref_mem[5]);
        end
        req0_valid = 1'b0;
        step();
        chk("b2b_stop_ack", req0_ack, 1'b0);
        chk("b2b_stop_busy", busy, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                contend(3'($urandom_range(0, 7)), AW'($urandom), 1'($urandom),
                        3'($urandom_range(0, 7)), AW'($urandom), 1'($urandom));
            end else begin
                issue(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      AW'($urandom), 1'($urandom));
            end
        end

        for (int i = 0; i < int'(NW); i++) chk("ram_final", ram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
